ddram_arbiter: RTL

// - Shares the single DDRAM port of emu between two requesters.
//   - Port A: burst reader, e.g. a framebuffer/video line fetcher.
//   - Port B: single-word read/write, e.g. the core CPU or ioctl loader.
// - Sequences each DDRAM transaction: command issue, DDRAM_BUSY wait-states, read-beat collection.
// - Fixed priority to A, with a starvation guard that guarantees B service.

---
 rtl/ddram_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/ddram_arbiter.sv
// ddram_arbiter: shares the single DDRAM port between a burst reader (A) and a single-word read/write port (B)
// A: a_req/a_addr/a_burst in; a_ack, a_dout/a_valid/a_done out
// B: b_rd/b_wr/b_addr/b_din/b_be in; b_busy, b_dout/b_valid out
// DDRAM: ddr_busy/ddr_dout/ddr_dout_ready in; ddr_rd/ddr_we/ddr_addr/ddr_burstcnt/ddr_din/ddr_be out
module ddram_arbiter #(
  parameter int A_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic [28:0] a_addr,
  input  logic [7:0]  a_burst,
  output logic        a_ack,
  output logic [63:0] a_dout,
  output logic        a_valid,
  output logic        a_done,
  input  logic        b_rd,
  input  logic        b_wr,
  input  logic [28:0] b_addr,
  input  logic [63:0] b_din,
  input  logic [7:0]  b_be,
  output logic        b_busy,
  output logic [63:0] b_dout,
  output logic        b_valid,
  input  logic        ddr_busy,
  input  logic [63:0] ddr_dout,
  input  logic        ddr_dout_ready,
  output logic        ddr_rd,
  output logic        ddr_we,
  output logic [28:0] ddr_addr,
  output logic [7:0]  ddr_burstcnt,
  output logic [63:0] ddr_din,
  output logic [7:0]  ddr_be
);
  typedef enum logic [2:0] {IDLE, A_CMD, A_DATA, B_CMD, B_DATA} state_t;
  state_t state, state_nx;
  logic [3:0] acnt;
  logic [7:0] beat;
  logic b_we;
  logic [28:0] b_addr_q;
  logic [63:0] b_din_q;
  logic [7:0] b_be_q;
  logic idle, grant_a, grant_b, a_beat, a_last, b_beat, b_done;
  always_comb begin
    idle = state == IDLE;
    grant_b = b_busy && (!a_req || acnt == 4'(A_MAX));
    grant_a = a_req && !grant_b;
    a_beat = (state == A_CMD || state == A_DATA) && ddr_dout_ready;
    a_last = beat == ddr_burstcnt - 8'd1;
    b_beat = state == B_DATA && ddr_dout_ready;
    b_done = b_beat || (state == B_CMD && !ddr_busy && b_we);
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant_b ? B_CMD : grant_a ? A_CMD : IDLE;
      A_CMD:   state_nx = (a_beat && a_last) ? IDLE : !ddr_busy ? A_DATA : A_CMD;
      A_DATA:  state_nx = (a_beat && a_last) ? IDLE : A_DATA;
      B_CMD:   state_nx = ddr_busy ? B_CMD : b_we ? IDLE : B_DATA;
      B_DATA:  state_nx = ddr_dout_ready ? IDLE : B_DATA;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_ack <= 1'b0;
      a_dout <= '0;
      a_valid <= 1'b0;
      a_done <= 1'b0;
      b_busy <= 1'b0;
      b_dout <= '0;
      b_valid <= 1'b0;
      ddr_rd <= 1'b0;
      ddr_we <= 1'b0;
      ddr_addr <= '0;
      ddr_burstcnt <= '0;
      ddr_din <= '0;
      ddr_be <= '0;
      acnt <= '0;
      beat <= '0;
      b_we <= 1'b0;
      b_addr_q <= '0;
      b_din_q <= '0;
      b_be_q <= '0;
    end else begin
      a_ack <= idle && grant_a;
      a_valid <= a_beat;
      a_done <= a_beat && a_last;
      if (a_beat) a_dout <= ddr_dout;
      beat <= idle ? 8'd0 : beat + 8'(a_beat);
      b_valid <= b_beat;
      if (b_beat) b_dout <= ddr_dout;
      // command strobes follow the state we are entering, so they rise with the grant
      ddr_rd <= state_nx == A_CMD || (state_nx == B_CMD && !b_we);
      ddr_we <= state_nx == B_CMD && b_we;
      if (idle && grant_a) begin
        ddr_addr <= a_addr;
        ddr_burstcnt <= (a_burst == 8'd0) ? 8'd1 : a_burst;
        acnt <= b_busy ? acnt + 4'd1 : 4'd0;
      end
      if (idle && grant_b) begin
        ddr_addr <= b_addr_q;
        ddr_burstcnt <= 8'd1;
        ddr_din <= b_din_q;
        ddr_be <= b_be_q;
        acnt <= 4'd0;
      end
      // write wins when both strobes arrive together
      if (!b_busy && (b_rd || b_wr)) begin
        b_busy <= 1'b1;
        b_we <= b_wr;
        b_addr_q <= b_addr;
        b_din_q <= b_din;
        b_be_q <= b_be;
      end else if (b_done) b_busy <= 1'b0;
    end
  end
endmodule
